imem_responder: RTL

- Instruction-memory responder: the memory-side end of the core's instruction fetch interface.
- Takes the core's fetch address and answers with ready/rdata after a programmable number of wait states.
- Backed by a word array that is preloaded through a separate load port.
- Sits between the core top and simulation/formal harnesses. It replaces free-running random ready/rdata with a deterministic, stallable memory model.

---
 rtl/imem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Memory-side end of the core's instruction fetch interface. Captures the
//   fetch byte address, waits a programmable number of cycles (freezable via
//   stall), then answers with a one-cycle ready pulse carrying the word from a
//   preloadable array, or NOP_WORD with fault set for misaligned or
//   out-of-range addresses.
//
// Ports
//   clock, reset      : single clock, synchronous active-high reset
//   io_imem_addr      : fetch byte address from the core
//   io_imem_ready     : one-cycle response pulse
//   io_imem_rdata     : instruction word (holds its value between pulses)
//   io_imem_fault     : misaligned / out-of-range flag, only ever high with ready
//   stall             : freezes the wait counter while in WAIT
//   busy              : high while a fetch is in flight (WAIT or RESP)
//   load_en/addr/data : array write port, usable in any state including reset
//
// State | meaning
// IDLE  | capture the presented address, start the wait counter
// WAIT  | counting wait states; an address change restarts the fetch
// RESP  | ready pulse with registered rdata/fault for the captured address

module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              io_imem_addr,
  output logic                     io_imem_ready,
  output logic [31:0]              io_imem_rdata,
  output logic                     io_imem_fault,
  input  logic                     stall,
  output logic                     busy,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] RELOAD  = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   acc_addr;
  logic [CW-1:0] counter;
  logic [31:0]   mem [DEPTH];

  logic          capture;
  logic          enter_resp;
  logic [31:0]   lookup_addr;
  logic          borrow;
  logic [29:0]   word_off;
  logic [AW-1:0] lookup_idx;
  logic          lookup_fault;

  // The lookup must see the address being captured on this edge so that a
  // LATENCY==1 fetch reads the right word on its IDLE->RESP edge. When WAIT
  // reaches RESP without a recapture the live address equals acc_addr anyway.
  always_comb begin
    capture = 1'b0;
    case (state)
      IDLE:    capture = 1'b1;
      WAIT:    capture = (io_imem_addr != acc_addr);
      default: capture = 1'b0;
    endcase

    lookup_addr = capture ? io_imem_addr : acc_addr;

    // (addr - BASE) >> 2 computed on the word part with the borrow from the
    // byte part, so the full 30-bit word offset is available for the range
    // compare without truncation.
    borrow       = (lookup_addr[1:0] < BASE_ADDR[1:0]);
    word_off     = lookup_addr[31:2] - BASE_ADDR[31:2] - 30'(borrow);
    lookup_idx   = word_off[AW-1:0];
    lookup_fault = (lookup_addr[1:0] != 2'b00) ||
                   ({2'b00, word_off} >= 32'(DEPTH));

    enter_resp = 1'b0;
    if (state == IDLE) begin
      enter_resp = (LATENCY == 1);
    end else if (state == WAIT) begin
      if (capture) enter_resp = (LATENCY == 1);
      else         enter_resp = !stall && (counter <= CNT_ONE);
    end
  end

  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      acc_addr      <= '0;
      counter       <= '0;
      io_imem_ready <= 1'b0;
      io_imem_rdata <= '0;
      io_imem_fault <= 1'b0;
      busy          <= 1'b0;
    end else begin
      io_imem_ready <= 1'b0;
      // fault is a qualifier of the ready pulse, so it drops with it;
      // rdata keeps the last returned word.
      io_imem_fault <= 1'b0;

      if (capture) begin
        acc_addr <= io_imem_addr;
        counter  <= RELOAD;
      end else if (state == WAIT && !stall && counter > CNT_ONE) begin
        counter <= counter - CNT_ONE;
      end

      if (enter_resp) begin
        state         <= RESP;
        busy          <= 1'b1;
        io_imem_ready <= 1'b1;
        io_imem_fault <= lookup_fault;
        io_imem_rdata <= lookup_fault ? NOP_WORD : mem[lookup_idx];
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT;
            busy  <= 1'b1;
          end
          WAIT: begin
            state <= WAIT;
            busy  <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
